fx_mod_ctrl: RTL and testbench



---
 rtl/fx_pkg.sv | 31 +++
 rtl/fx_slew_limiter.sv | 21 ++
 rtl/fx_mod_ctrl.sv | 132 +++++++++++++
 tb/tb_fx_mod_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared types and constants for the flanger modulation controller.
// FX_MOD_SINE_EN adds the quarter-wave sine table used for the sine tap shape.
package fx_pkg;

   localparam int DELAY_W   = 7;
   localparam int SLIDER_W  = 12;
   localparam int PHASE_W   = 17;
   localparam int SLEW_STEP = 16;
   localparam int MAX_TAP   = (1 << DELAY_W) - 1;
   localparam int ALPHA_W   = SLIDER_W + 1;
   localparam int FILL_W    = DELAY_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      LFO,
      SLEW,
      PUBLISH
   } fsm_state_e;

`ifdef FX_MOD_SINE_EN
   // q[i] = round(63*sin(pi/2*i/63)); entry 21 lands at 31 because 63*sin(pi/6) sits just under 31.5
   localparam logic [5:0] SINE_Q [64] = '{
       0,  2,  3,  5,  6,  8,  9, 11, 12, 14, 16, 17, 19, 20, 22, 23,
      24, 26, 27, 29, 30, 31, 33, 34, 35, 37, 38, 39, 40, 42, 43, 44,
      45, 46, 47, 48, 49, 50, 51, 52, 53, 54, 55, 55, 56, 57, 57, 58,
      59, 59, 60, 60, 61, 61, 61, 62, 62, 62, 63, 63, 63, 63, 63, 63
   };
`endif

endpackage

// File: rtl/fx_slew_limiter.sv
// Combinational slew limiter: moves current toward target by at most step,
// landing exactly on target once it is within reach. Values are unsigned.
module fx_slew_limiter #(
   parameter int W = 13
) (
   input  logic [W-1:0] target,
   input  logic [W-1:0] current,
   input  logic [W-1:0] step,
   output logic [W-1:0] result
);

   always_comb begin
      result = target;
      if (target > current) begin
         if ((target - current) > step) result = current + step;
      end else if ((current - target) > step) begin
         result = current - step;
      end
   end

endmodule

// File: rtl/fx_mod_ctrl.sv
// Per-frame LFO / mix controller for the flanger delay line: tick detect, phase
// accumulator, slewed alpha, warm-up gating. FX_MOD_SINE_EN selects a sine tap shape.
module fx_mod_ctrl
   import fx_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                VALID,
   input  logic [SLIDER_W-1:0] rate_slider,
   input  logic [SLIDER_W-1:0] vol_slider,
   input  logic                bypass,
   output logic [DELAY_W-1:0]  delay_samples,
   output logic [ALPHA_W-1:0]  alpha,
   output logic                mix_en,
   output logic                cfg_upd,
   output logic                overrun
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(1 << DELAY_W);

   fsm_state_e          state, state_n;
   logic                v1, v2, tick, pending;
   logic [SLIDER_W-1:0] rate_q, vol_q;
   logic                byp_q;
   logic [PHASE_W-1:0]  phase;
   logic [ALPHA_W-1:0]  alpha_trk, alpha_nxt, target;
   logic [FILL_W-1:0]   fill, fill_n;
   logic                full_n;
   logic [DELAY_W-1:0]  tap_n;

   assign tick = ~v1 & v2;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (tick || pending) state_n = CAPTURE;
         CAPTURE: state_n = LFO;
         LFO:     state_n = SLEW;
         SLEW:    state_n = PUBLISH;
         PUBLISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      target = byp_q ? '0 : {1'b0, vol_q};
      fill_n = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      full_n = (fill_n == FILL_FULL);
   end

   fx_slew_limiter #(.W(ALPHA_W)) u_slew (
      .target  (target),
      .current (alpha_trk),
      .step    (ALPHA_W'(SLEW_STEP)),
      .result  (alpha_nxt)
   );

`ifdef FX_MOD_SINE_EN
   logic [1:0] quad;
   logic [5:0] sin_idx, q_fwd, q_rev;

   always_comb begin
      quad    = phase[PHASE_W-1 -: 2];
      sin_idx = phase[PHASE_W-3 -: 6];
      q_fwd   = SINE_Q[sin_idx];
      q_rev   = SINE_Q[~sin_idx];
      case (quad)
         2'd0:    tap_n = 7'd64 + {1'b0, q_fwd};
         2'd1:    tap_n = 7'd64 + {1'b0, q_rev};
         2'd2:    tap_n = 7'd63 - {1'b0, q_fwd};
         default: tap_n = 7'd63 - {1'b0, q_rev};
      endcase
   end
`else
   logic [DELAY_W-1:0] tri_t;

   always_comb begin
      tri_t = phase[PHASE_W-2 -: DELAY_W];
      tap_n = phase[PHASE_W-1] ? (DELAY_W'(MAX_TAP) - tri_t) : tri_t;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         v1            <= 1'b0;
         v2            <= 1'b0;
         pending       <= 1'b0;
         overrun       <= 1'b0;
         rate_q        <= '0;
         vol_q         <= '0;
         byp_q         <= 1'b0;
         phase         <= '0;
         alpha_trk     <= '0;
         fill          <= '0;
         delay_samples <= '0;
         alpha         <= '0;
         mix_en        <= 1'b0;
         cfg_upd       <= 1'b0;
      end else begin
         v1      <= VALID;
         v2      <= v1;
         state   <= state_n;
         cfg_upd <= 1'b0;
         // A tick arriving in IDLE alongside pending replaces the consumed one.
         if (state == IDLE) begin
            if (pending && !tick) pending <= 1'b0;
         end else if (tick) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
         end
         case (state)
            CAPTURE: begin
               rate_q <= rate_slider;
               vol_q  <= vol_slider;
               byp_q  <= bypass;
            end
            LFO: if (!byp_q) phase <= phase + {{(PHASE_W-SLIDER_W){1'b0}}, rate_q} + PHASE_W'(1);
            SLEW: alpha_trk <= alpha_nxt;
            PUBLISH: begin
               fill          <= fill_n;
               mix_en        <= full_n;
               alpha         <= full_n ? alpha_trk : '0;
               delay_samples <= tap_n;
               cfg_upd       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fx_mod_ctrl.sv
// Directed + randomized bench for fx_mod_ctrl against a frame-level reference model.
module tb_fx_mod_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        VALID;
   logic [11:0] rate_slider, vol_slider;
   logic        bypass;
   logic [6:0]  delay_samples;
   logic [12:0] alpha;
   logic        mix_en, cfg_upd, overrun;

   int checks = 0;
   int errors = 0;

   int m_phase, m_alpha_int, m_fill, m_alpha, m_delay, m_mix, m_overrun;

   always #5 clk = ~clk;

   fx_mod_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .VALID         (VALID),
      .rate_slider   (rate_slider),
      .vol_slider    (vol_slider),
      .bypass        (bypass),
      .delay_samples (delay_samples),
      .alpha         (alpha),
      .mix_en        (mix_en),
      .cfg_upd       (cfg_upd),
      .overrun       (overrun)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

`ifdef FX_MOD_SINE_EN
   function automatic int qv(input int i);
      return int'($floor(63.0 * $sin(3.14159265358979323846 / 2.0 * i / 63.0) + 0.5));
   endfunction
`endif

   function automatic int model_tap(input int ph);
`ifdef FX_MOD_SINE_EN
      int idx, quad;
      idx  = (ph / 512) % 64;
      quad = ph / 32768;
      case (quad)
         0:       return 64 + qv(idx);
         1:       return 64 + qv(63 - idx);
         2:       return 63 - qv(idx);
         default: return 63 - qv(63 - idx);
      endcase
`else
      int t;
      t = (ph / 512) % 128;
      return (ph >= 65536) ? 127 - t : t;
`endif
   endfunction

   task automatic model_reset();
      m_phase = 0; m_alpha_int = 0; m_fill = 0;
      m_alpha = 0; m_delay = 0; m_mix = 0; m_overrun = 0;
   endtask

   task automatic model_frame(input int rate, input int vol, input int byp);
      int tgt;
      if (byp == 0) m_phase = (m_phase + rate + 1) % 131072;
      tgt = (byp != 0) ? 0 : vol;
      if (tgt > m_alpha_int)      m_alpha_int = (tgt - m_alpha_int > 16) ? m_alpha_int + 16 : tgt;
      else if (tgt < m_alpha_int) m_alpha_int = (m_alpha_int - tgt > 16) ? m_alpha_int - 16 : tgt;
      if (m_fill < 128) m_fill++;
      m_mix   = (m_fill == 128) ? 1 : 0;
      m_alpha = (m_mix != 0) ? m_alpha_int : 0;
      m_delay = model_tap(m_phase);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_delay"},   int'(delay_samples), m_delay);
      check({tag, "_alpha"},   int'(alpha),         m_alpha);
      check({tag, "_mix_en"},  int'(mix_en),        m_mix);
      check({tag, "_overrun"}, int'(overrun),       m_overrun);
   endtask

   // One frame: VALID high for two clocks, then a falling edge; sliders are
   // scrambled once capture is over to show later changes are ignored.
   task automatic run_frame(input int rate, input int vol, input int byp, input string tag);
      int lat;
      rate_slider = 12'(rate);
      vol_slider  = 12'(vol);
      bypass      = byp[0];
      VALID = 1'b1;
      repeat (2) @(negedge clk);
      VALID = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 3) begin
            rate_slider = 12'($urandom);
            vol_slider  = 12'($urandom);
            bypass      = 1'($urandom);
         end
         if (cfg_upd) begin
            lat = k;
            break;
         end
      end
      model_frame(rate, vol, byp);
      check({tag, "_latency"}, lat, 6);
      check_outputs(tag);
      @(negedge clk);
      check({tag, "_pulse_width"}, int'(cfg_upd), 0);
   endtask

   initial begin
      int pulses;
      int r, v, b;

      rst = 1'b1; VALID = 1'b0; rate_slider = '0; vol_slider = '0; bypass = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_cfg_upd", int'(cfg_upd), 0);
      check_outputs("rst");
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cfg_upd", int'(cfg_upd), 0);

      // First frame, then warm-up to the 128th publish with random rates.
      run_frame(0, 12'hFF0, 0, "first");
      check("first_phase_model", m_phase, 1);
      for (int i = 2; i <= 128; i++) run_frame(int'($urandom_range(0, 4095)), 12'hFF0, 0, "warm");
      check("warm_mix_final", int'(mix_en), 1);

      // Volume moves and bypass fade after warm-up.
      for (int i = 0; i < 8; i++) run_frame(100, 12'h000, 0, "vol0");
      for (int i = 0; i < 6; i++) run_frame(100, 12'h040, 0, "vol40");
      for (int i = 0; i < 6; i++) run_frame(100, 12'h040, 1, "bypass");

      for (int i = 0; i < 30; i++) begin
         r = int'($urandom_range(0, 4095));
         v = int'($urandom_range(0, 4095));
         b = ($urandom_range(0, 3) == 0) ? 1 : 0;
         run_frame(r, v, b, "rand");
      end

      // Three ticks in quick succession: one processed, one pending, one lost.
      rate_slider = 12'd777; vol_slider = 12'd300; bypass = 1'b0;
      VALID = 1'b1;
      repeat (2) @(negedge clk);
      VALID = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         pulses += int'(cfg_upd);
         if (k == 1 || k == 3) VALID = 1'b1;
         if (k == 2 || k == 4) VALID = 1'b0;
      end
      model_frame(777, 300, 0);
      model_frame(777, 300, 0);
      m_overrun = 1;
      check("ovr_pulses", pulses, 2);
      check_outputs("ovr");
      run_frame(50, 200, 0, "ovr_sticky");

      // Reset mid-frame with a tick pending: nothing may be published afterwards.
      VALID = 1'b1;
      repeat (2) @(negedge clk);
      VALID = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) VALID = 1'b1;
         if (k == 2) VALID = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("midrst_cfg_upd", int'(cfg_upd), 0);
      check_outputs("midrst");
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         pulses += int'(cfg_upd);
      end
      check("midrst_no_publish", pulses, 0);

      // Full-rate sweep from phase 0 across the triangle fold and wrap.
      for (int i = 0; i < 40; i++) run_frame(12'hFFF, 12'h123, 0, "sweep");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
